// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// datapath select encodings and the bundled control-output record.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;
    localparam logic       REGDST_RT   = 1'b0;
    localparam logic       REGDST_RD   = 1'b1;
    localparam logic       WB_ALUOUT   = 1'b0;
    localparam logic       WB_MDR      = 1'b1;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT= 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       mdr_en;
        logic       ab_en;
        logic       aluout_en;
        logic       rf_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
        logic       illegal;
    } ctrl_out_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HLT: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller (slave side) and the
// datapath/memory that feeds it status and consumes its enables and selects.
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       ir_en;
    logic       mdr_en;
    logic       ab_en;
    logic       aluout_en;
    logic       rf_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       halted;
    logic       illegal;

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_en, ir_en, mdr_en, ab_en, aluout_en, rf_we, mem_rd, mem_wr,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, halted, illegal
    );

    modport master (
        output opcode, zero, mem_ready,
        input  pc_en, ir_en, mdr_en, ab_en, aluout_en, rf_we, mem_rd, mem_wr,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, halted, illegal
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational state-to-control decode. Everything is forced low while
// reset is held so no strobe escapes during an asynchronous clear.
module ctrl_out_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic       i_clr,
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_out_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        if (!i_clr) begin
            case (i_state)
                S_FETCH: begin
                    o_ctrl.mem_rd    = 1'b1;
                    o_ctrl.iord      = IORD_PC;
                    o_ctrl.alu_src_a = SRCA_PC;
                    o_ctrl.alu_src_b = SRCB_ONE;
                    o_ctrl.alu_op    = ALUOP_ADD;
                    o_ctrl.pc_src    = PCSRC_ALU;
                    o_ctrl.ir_en     = i_mem_ready;
                    o_ctrl.pc_en     = i_mem_ready;
                end
                S_DECODE: begin
                    o_ctrl.ab_en   = 1'b1;
                    o_ctrl.illegal = !op_is_legal(i_opcode);
                end
                S_EXEC_R: begin
                    o_ctrl.alu_src_a = SRCA_A;
                    o_ctrl.alu_src_b = SRCB_B;
                    o_ctrl.alu_op    = ALUOP_FUNCT;
                    o_ctrl.aluout_en = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    o_ctrl.alu_src_a = SRCA_A;
                    o_ctrl.alu_src_b = SRCB_IMM;
                    o_ctrl.alu_op    = ALUOP_ADD;
                    o_ctrl.aluout_en = 1'b1;
                end
                S_MEM_RD: begin
                    o_ctrl.mem_rd = 1'b1;
                    o_ctrl.iord   = IORD_ALUOUT;
                    o_ctrl.mdr_en = i_mem_ready;
                end
                S_MEM_WB: begin
                    o_ctrl.rf_we      = 1'b1;
                    o_ctrl.reg_dst    = REGDST_RT;
                    o_ctrl.mem_to_reg = WB_MDR;
                end
                S_MEM_WR: begin
                    o_ctrl.mem_wr = 1'b1;
                    o_ctrl.iord   = IORD_ALUOUT;
                end
                S_RWB: begin
                    // IR is frozen after fetch, so the opcode still tells R-type from ADDI.
                    o_ctrl.rf_we      = 1'b1;
                    o_ctrl.reg_dst    = (i_opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                    o_ctrl.mem_to_reg = WB_ALUOUT;
                end
                S_BRANCH: begin
                    o_ctrl.alu_src_a = SRCA_A;
                    o_ctrl.alu_src_b = SRCB_B;
                    o_ctrl.alu_op    = ALUOP_SUB;
                    o_ctrl.pc_src    = PCSRC_ALUOUT;
                    o_ctrl.pc_en     = i_zero;
                end
                S_JUMP: begin
                    o_ctrl.pc_en  = 1'b1;
                    o_ctrl.pc_src = PCSRC_JUMP;
                end
                S_HALT: begin
                    o_ctrl.halted = 1'b1;
                end
                default: o_ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: state register plus next-state logic, with the
// per-state control outputs produced by ctrl_out_decode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               CLR,
    multicycle_ctrl_if.slave   bus
);

    state_t    r_state;
    state_t    w_state_next;
    ctrl_out_t w_ctrl;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) r_state <= S_FETCH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:    w_state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      w_state_next = S_EXEC_R;
                    OP_ADDI:       w_state_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_state_next = S_MEM_ADDR;
                    OP_BEQ:        w_state_next = S_BRANCH;
                    OP_JMP:        w_state_next = S_JUMP;
                    OP_HLT:        w_state_next = S_HALT;
                    default:       w_state_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_state_next = S_RWB;
            S_MEM_ADDR: w_state_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_state_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_MEM_WB, S_RWB, S_BRANCH, S_JUMP: w_state_next = S_FETCH;
            S_HALT:     w_state_next = S_HALT;
            default:    w_state_next = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .i_clr       (CLR),
        .i_state     (r_state),
        .i_opcode    (bus.opcode),
        .i_zero      (bus.zero),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.pc_en      = w_ctrl.pc_en;
    assign bus.ir_en      = w_ctrl.ir_en;
    assign bus.mdr_en     = w_ctrl.mdr_en;
    assign bus.ab_en      = w_ctrl.ab_en;
    assign bus.aluout_en  = w_ctrl.aluout_en;
    assign bus.rf_we      = w_ctrl.rf_we;
    assign bus.mem_rd     = w_ctrl.mem_rd;
    assign bus.mem_wr     = w_ctrl.mem_wr;
    assign bus.iord       = w_ctrl.iord;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.pc_src     = w_ctrl.pc_src;
    assign bus.halted     = w_ctrl.halted;
    assign bus.illegal    = w_ctrl.illegal;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// sequence of controller steps and every cycle's outputs are checked.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, rf_we;
        logic       mem_rd, mem_wr, iord, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic [3:0] state;
        logic       halted, illegal;
    } ov_t;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;
    ov_t  exp_v;
    ov_t  dut_v;
    bit   exp_valid = 1'b0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign dut_v = {bus.pc_en, bus.ir_en, bus.mdr_en, bus.ab_en, bus.aluout_en, bus.rf_we,
                    bus.mem_rd, bus.mem_wr, bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_src, bus.state, bus.halted, bus.illegal};

    // Single compare point, half a period away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_v !== exp_v) begin
                failures++;
                $display("FAIL outputs t=%0t act=%h exp=%h (state act=%0d exp=%0d)",
                         $time, dut_v, exp_v, dut_v.state, exp_v.state);
            end
        end
    end

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15};
    endfunction

    // Expected outputs of one step, straight from the per-state rules.
    function automatic ov_t model(input int code, input bit rdy, input bit z, input logic [3:0] op);
        ov_t v;
        v = '0;
        v.state = 4'(code);
        case (code)
            0:  begin v.mem_rd = 1; v.alu_src_b = 2'b01; v.ir_en = rdy; v.pc_en = rdy; end
            1:  begin v.ab_en = 1; v.illegal = !is_legal(op); end
            2:  begin v.alu_src_a = 1; v.alu_op = 2'b10; v.aluout_en = 1; end
            3, 4: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.aluout_en = 1; end
            5:  begin v.mem_rd = 1; v.iord = 1; v.mdr_en = rdy; end
            6:  begin v.rf_we = 1; v.mem_to_reg = 1; end
            7:  begin v.mem_wr = 1; v.iord = 1; end
            8:  begin v.rf_we = 1; v.reg_dst = (op == 4'd0); end
            9:  begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_src = 2'b01; v.pc_en = z; end
            10: begin v.pc_en = 1; v.pc_src = 2'b10; end
            11: v.halted = 1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Asynchronous clear a few ns into the cycle; expects all-zero outputs before the next edge.
    task automatic clr_pulse();
        #2;
        clr = 1'b1;
        exp_v = '0;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Called at posedge+1 with the controller in FETCH; returns the same way.
    // stall<0: random memory latency, otherwise exactly 'stall' wait cycles per access.
    task automatic run_instr(input logic [3:0] op, input int stall, input int zsel,
                             input int halt_n, input bit allow_abort);
        int path[$];
        path = {0, 1};
        case (op)
            4'd0:  path = {0, 1, 2, 8};
            4'd1:  path = {0, 1, 3, 8};
            4'd2:  path = {0, 1, 4, 5, 6};
            4'd3:  path = {0, 1, 4, 7};
            4'd4:  path = {0, 1, 9};
            4'd5:  path = {0, 1, 10};
            default: path = {0, 1};
        endcase
        foreach (path[i]) begin
            int  code;
            int  waited;
            bit  done;
            bit  rdy;
            bit  z;
            bit  waits;
            code   = path[i];
            waited = 0;
            done   = 0;
            waits  = (code == 0) || (code == 5) || (code == 7);
            while (!done) begin
                if (stall < 0) rdy = ($urandom_range(0, 2) != 0) || (waited >= 30);
                else           rdy = (waited >= stall);
                if (!waits) rdy = 1'($urandom_range(0, 1));
                z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
                bus.opcode    = (code == 0) ? 4'($urandom_range(0, 15)) : op;
                bus.mem_ready = rdy;
                bus.zero      = z;
                exp_v         = model(code, rdy, z, op);
                exp_valid     = 1'b1;
                if (allow_abort && $urandom_range(0, 39) == 0) begin
                    clr_pulse();
                    return;
                end
                @(posedge clk); #1;
                if (!waits || rdy) done = 1;
                else               waited++;
            end
        end
        if (op == 4'd15) begin
            for (int k = 0; k < halt_n; k++) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.zero      = 1'($urandom_range(0, 1));
                exp_v         = model(11, bus.mem_ready, bus.zero, op);
                @(posedge clk); #1;
            end
            clr_pulse();
        end
    endtask

    // Zero-wait instruction length measured purely from the DUT's state output.
    task automatic measure(input logic [3:0] op, input int lit, input string name);
        int n;
        n = 0;
        exp_valid     = 1'b0;
        bus.opcode    = op;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.state != 4'd0 && n < 20);
        checks++;
        if (n != lit) begin
            failures++;
            $display("FAIL cycles_%s act=%0d exp=%0d", name, n, lit);
        end
        $display("measure %s cycles=%0d", name, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr           = 1'b1;
        bus.opcode    = 4'd0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        exp_v         = '0;
        exp_valid     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;

        measure(4'd0, 4, "rtype");
        measure(4'd1, 4, "addi");
        measure(4'd2, 5, "lw");
        measure(4'd3, 4, "sw");
        measure(4'd4, 3, "beq");
        measure(4'd5, 3, "jmp");
        measure(4'd7, 2, "illegal");

        run_instr(4'd1, 0, -1, 0, 0);
        $display("directed addi zero-wait");
        run_instr(4'd2, 3, -1, 0, 0);
        $display("directed lw stall=3");
        run_instr(4'd4, 0, 1, 0, 0);
        $display("directed beq zero=1");
        run_instr(4'd4, 0, 0, 0, 0);
        $display("directed beq zero=0");
        run_instr(4'd7, 0, -1, 0, 0);
        $display("directed illegal 0111");
        run_instr(4'd15, 0, -1, 20, 0);
        $display("directed hlt 20 cycles then clr");

        for (int n = 0; n < 400; n++) begin
            int         sel;
            logic [3:0] op;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      op = 4'(sel);
            else if (sel <= 7) op = 4'($urandom_range(6, 14));
            else if (sel == 8) op = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'd2;
            else               op = 4'd3;
            run_instr(op, -1, -1, $urandom_range(2, 8), 1'b1);
            $display("instr %0d op=%b checks=%0d failures=%0d", n, op, checks, failures);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
